// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: Moore decode of control signals, memory
// stall tracking with timeout, illegal-opcode trap and a registered retire pulse.
module multicycle_controller #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic [1:0] fault
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, FAULT
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    // The stall that would bring the counter to MAX_WAIT is the one that faults.
    localparam logic [7:0] LIMIT   = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] fault_q, fault_d;
    logic       done_q, done_d;
    logic       timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            fault_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = '0;
        ALUSrcA   = '0;
        ALUSrcB   = '0;
        ALUOp     = '0;
        timeout   = !mem_ready && (wait_q == LIMIT);

        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = DECODE;
                else if (timeout) begin
                    state_d = FAULT;
                    fault_d = 2'b10;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d = FAULT;
                        fault_d = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEMWB;
                else if (timeout) begin
                    state_d = FAULT;
                    fault_d = 2'b10;
                end
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = FETCH;
                else if (timeout) begin
                    state_d = FAULT;
                    fault_d = 2'b10;
                end
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
                state_d = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            wait_d = '0;
        else if (mem_req && !mem_ready)
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;

        done_d = (state_d == FETCH) &&
                 (state_q == MEMWB || state_q == MEMWRITE ||
                  state_q == ALUWB || state_q == BEQ);
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign instr_done = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-scenario tasks compare the packed
// control vector against hand-written per-state constants.
module tb_multicycle_controller;

    logic       clk, rst, run, zero, mem_ready;
    logic [6:0] op;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault;
    logic [16:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    // {mem_req,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite}_ResultSrc_ALUSrcA_ALUSrcB_ALUOp_done_fault
    localparam logic [16:0] IDLE_V = 17'b000000_00_00_00_00_0_00;
    localparam logic [16:0] F_RDY  = 17'b110010_10_00_10_00_0_00;
    localparam logic [16:0] F_RDYD = 17'b110010_10_00_10_00_1_00;
    localparam logic [16:0] F_STL  = 17'b100000_10_00_10_00_0_00;
    localparam logic [16:0] DEC    = 17'b000000_00_01_01_00_0_00;
    localparam logic [16:0] MADR   = 17'b000000_00_10_01_00_0_00;
    localparam logic [16:0] MRD    = 17'b101000_00_00_00_00_0_00;
    localparam logic [16:0] MWB    = 17'b000001_01_00_00_00_0_00;
    localparam logic [16:0] MWR    = 17'b101100_00_00_00_00_0_00;
    localparam logic [16:0] EXR    = 17'b000000_00_10_00_10_0_00;
    localparam logic [16:0] EXI    = 17'b000000_00_10_01_10_0_00;
    localparam logic [16:0] AWB    = 17'b000001_00_00_00_00_0_00;
    localparam logic [16:0] BEQ1   = 17'b010000_00_10_00_01_0_00;
    localparam logic [16:0] BEQ0   = 17'b000000_00_10_00_01_0_00;
    localparam logic [16:0] JALV   = 17'b010000_00_01_10_00_0_00;
    localparam logic [16:0] FLT_IL = 17'b000000_00_00_00_00_0_01;
    localparam logic [16:0] FLT_TO = 17'b000000_00_00_00_00_0_10;

    assign ctl = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, fault};

    multicycle_controller #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = 7'b0100011;
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, IDLE_V);
        end
        n_checks++;
        if (ImmSrc !== 2'b01) begin
            n_fail++; $display("FAIL reset_immsrc: got %b expected 01", ImmSrc);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (ctl !== F_RDY) begin
            n_fail++; $display("FAIL reset_first_fetch: got %b expected %b", ctl, F_RDY);
        end
    endtask

    task automatic test_rtype;
        do_reset();
        run = 1'b1; op = 7'b0110011; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++; $display("FAIL rtype_idle: got %b expected %b", ctl, IDLE_V);
        end
        tick();
        n_checks++;
        if (ctl !== F_RDY) begin
            n_fail++; $display("FAIL rtype_fetch: got %b expected %b", ctl, F_RDY);
        end
        run = 1'b0;
        tick();
        n_checks++;
        if (ctl !== DEC) begin
            n_fail++; $display("FAIL rtype_decode: got %b expected %b", ctl, DEC);
        end
        tick();
        n_checks++;
        if (ctl !== EXR) begin
            n_fail++; $display("FAIL rtype_execute: got %b expected %b", ctl, EXR);
        end
        tick();
        n_checks++;
        if (ctl !== AWB) begin
            n_fail++; $display("FAIL rtype_aluwb: got %b expected %b", ctl, AWB);
        end
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL rtype_retire: got %b expected %b", ctl, F_RDYD);
        end
        tick();
        n_checks++;
        if (instr_done !== 1'b0) begin
            n_fail++; $display("FAIL rtype_done_pulse: got %b expected 0", instr_done);
        end
    endtask

    task automatic test_lw_stall;
        do_reset();
        run = 1'b1; op = 7'b0000011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (ctl !== MADR || ImmSrc !== 2'b00) begin
            n_fail++; $display("FAIL lw_memadr: got %b/%b expected %b/00", ctl, ImmSrc, MADR);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            #1;
            n_checks++;
            if (ctl !== MRD) begin
                n_fail++; $display("FAIL lw_memread%0d: got %b expected %b", i, ctl, MRD);
            end
        end
        tick();
        n_checks++;
        if (ctl !== MWB) begin
            n_fail++; $display("FAIL lw_memwb: got %b expected %b", ctl, MWB);
        end
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL lw_retire: got %b expected %b", ctl, F_RDYD);
        end
    endtask

    task automatic test_beq;
        do_reset();
        run = 1'b1; op = 7'b1100011; mem_ready = 1'b1; zero = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (ctl !== BEQ1 || ImmSrc !== 2'b10) begin
            n_fail++; $display("FAIL beq_taken: got %b/%b expected %b/10", ctl, ImmSrc, BEQ1);
        end
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL beq_retire: got %b expected %b", ctl, F_RDYD);
        end
        zero = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ctl !== BEQ0) begin
            n_fail++; $display("FAIL beq_not_taken: got %b expected %b", ctl, BEQ0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        run = 1'b1; op = 7'b0010011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (ctl !== EXI) begin
            n_fail++; $display("FAIL b2b_executei: got %b expected %b", ctl, EXI);
        end
        tick();
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL b2b_retire1: got %b expected %b", ctl, F_RDYD);
        end
        op = 7'b1101111;
        tick();
        tick();
        n_checks++;
        if (ctl !== JALV || ImmSrc !== 2'b11) begin
            n_fail++; $display("FAIL b2b_jal: got %b/%b expected %b/11", ctl, ImmSrc, JALV);
        end
        tick();
        n_checks++;
        if (ctl !== AWB) begin
            n_fail++; $display("FAIL b2b_jal_wb: got %b expected %b", ctl, AWB);
        end
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL b2b_retire2: got %b expected %b", ctl, F_RDYD);
        end
    endtask

    task automatic test_sw_timeout;
        do_reset();
        run = 1'b1; op = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            mem_ready = 1'b0;
            #1;
            n_checks++;
            if (ctl !== MWR) begin
                n_fail++; $display("FAIL sw_stall%0d: got %b expected %b", i, ctl, MWR);
            end
        end
        tick();
        n_checks++;
        if (ctl !== FLT_TO) begin
            n_fail++; $display("FAIL sw_timeout: got %b expected %b", ctl, FLT_TO);
        end
        mem_ready = 1'b1; run = 1'b1;
        tick();
        n_checks++;
        if (ctl !== FLT_TO) begin
            n_fail++; $display("FAIL sw_timeout_hold: got %b expected %b", ctl, FLT_TO);
        end
    endtask

    task automatic test_sw_limit_ready;
        do_reset();
        run = 1'b1; op = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            mem_ready = (i == 7);
            #1;
            n_checks++;
            if (ctl !== MWR) begin
                n_fail++; $display("FAIL sw_limit%0d: got %b expected %b", i, ctl, MWR);
            end
        end
        tick();
        n_checks++;
        if (ctl !== F_RDYD) begin
            n_fail++; $display("FAIL sw_limit_ready: got %b expected %b", ctl, F_RDYD);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        run = 1'b1; op = 7'b1111111; mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ctl !== DEC || ImmSrc !== 2'b00) begin
            n_fail++; $display("FAIL ill_decode: got %b/%b expected %b/00", ctl, ImmSrc, DEC);
        end
        tick();
        n_checks++;
        if (ctl !== FLT_IL) begin
            n_fail++; $display("FAIL ill_fault: got %b expected %b", ctl, FLT_IL);
        end
        tick();
        n_checks++;
        if (ctl !== FLT_IL) begin
            n_fail++; $display("FAIL ill_fault_hold: got %b expected %b", ctl, FLT_IL);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++; $display("FAIL ill_reset: got %b expected %b", ctl, IDLE_V);
        end
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++; $display("FAIL ill_idle_after_reset: got %b expected %b", ctl, IDLE_V);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        run = 1'b1; op = 7'b0110011; mem_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ctl !== F_STL) begin
            n_fail++; $display("FAIL async_fetch_stall: got %b expected %b", ctl, F_STL);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || ctl !== IDLE_V) begin
            n_fail++; $display("FAIL async_fetch_drop: got %b expected %b", ctl, IDLE_V);
        end
        tick();
        rst = 1'b1; run = 1'b1; op = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ctl !== MWR) begin
            n_fail++; $display("FAIL async_sw_stall: got %b expected %b", ctl, MWR);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || MemWrite !== 1'b0) begin
            n_fail++; $display("FAIL async_sw_drop: got mem_req=%b MemWrite=%b expected 0/0", mem_req, MemWrite);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_back_to_back();
        test_sw_timeout();
        test_sw_limit_ready();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: memory-stall cycles tolerated before a timeout fault (legal range 1..255).
REQ-002 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous and active-low.
REQ-004 SHALL have port run input 1: leave IDLE and start fetching.
REQ-005 SHALL have port op input 7: instruction opcode from the instruction register.
REQ-006 SHALL have port zero input 1: ALU zero flag.
REQ-007 SHALL have port mem_ready input 1: memory completes the current access this cycle.
REQ-008 SHALL have port mem_req output 1: memory access request.
REQ-009 SHALL have ports PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, each output 1.
REQ-010 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc, each output 2.
REQ-011 SHALL have port instr_done output 1: retire pulse.
REQ-012 SHALL have port fault output 2: 00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, FAULT; outputs SHALL be decoded from the state register, plus the qualifiers in REQ-017/018/022.
REQ-014 SHALL drive 0 on every control output not listed for the current state.
REQ-015 SHALL make the following transitions:
- IDLE->FETCH when run=1.
- FETCH->DECODE on mem_ready.
- DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FAULT with fault=01.
- MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD->MEMWB on mem_ready; MEMWB->FETCH.
- MEMWRITE->FETCH on mem_ready.
- EXECUTER, EXECUTEI and JAL -> ALUWB; ALUWB->FETCH; BEQ->FETCH.
- FAULT is terminal until reset.
REQ-016 SHALL drive these per-state outputs:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
REQ-017 SHALL assert IRWrite and PCWrite in FETCH only in a cycle with mem_ready=1.
REQ-018 SHALL assert PCWrite in BEQ equal to zero.
REQ-019 SHALL drive ImmSrc combinationally from op in all states: lw or I-type 00, sw 01, beq 10, jal 11, any other op 00.
REQ-020 SHALL hold mem_req, AdrSrc and MemWrite stable across stall cycles until mem_ready is sampled high.
REQ-021 SHALL keep an 8-bit wait counter:
- The counter increments each cycle with mem_req=1 and mem_ready=0, and clears on every state change.
- When the counter reaches MAX_WAIT with mem_ready still 0, the FSM SHALL enter FAULT with fault=10.
- mem_ready=1 in the same cycle as the limit is reached SHALL take priority (normal advance, no fault).
REQ-022 SHALL pulse instr_done for exactly one cycle on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
REQ-023 SHALL, in FAULT, drive all control outputs and mem_req to 0 and hold fault until reset.
REQ-024 SHALL ignore run outside IDLE.

Reset
REQ-025 SHALL, while rst=0, force state=IDLE, wait counter=0 and fault=00, with all control outputs, mem_req and instr_done at 0; ImmSrc SHALL still follow op.
REQ-026 SHALL, when rst is asserted mid-instruction (including during a memory stall), drop mem_req and MemWrite immediately (asynchronously), without waiting for a clock edge.
REQ-027 SHALL reach FETCH on the first rising edge with rst=1 and run=1.

Verification
REQ-028 SHALL cover: R-type (op=0110011), mem_ready=1 in FETCH -> FETCH, DECODE, EXECUTER, ALUWB; ALUOp=10 in EXECUTER; RegWrite=1 in ALUWB; instr_done at re-entry to FETCH; 4 cycles total.
REQ-029 SHALL cover: lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with AdrSrc=1, then MEMWB with ResultSrc=01 and RegWrite=1; no fault.
REQ-030 SHALL cover: beq with zero=1, then zero=0 -> PCWrite=1 in BEQ, then PCWrite=0 in BEQ; ALUOp=01 in both.
REQ-031 SHALL cover: sw with MAX_WAIT=8 and mem_ready held 0 -> FAULT after 8 stall cycles, fault=10, mem_req=0 thereafter; mem_ready=1 on the 8th stall cycle -> normal completion, no fault.
REQ-032 SHALL cover: op=1111111 in DECODE -> FAULT with fault=01; rst pulse -> IDLE and fault=00.
REQ-033 SHALL cover: rst asserted during a FETCH stall -> mem_req=0 before the next clock edge.
